// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between the fetch and load/store ports with a single
// outstanding transaction. The data port has priority, limited by a starvation counter.
module mem_port_arbiter #(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_DATA_STREAK = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    instr_req_i,
    input  logic [ADDR_WIDTH-1:0]   instr_addr_i,
    output logic                    instr_gnt_o,
    output logic                    instr_rvalid_o,
    output logic [DATA_WIDTH-1:0]   instr_rdata_o,
    input  logic                    data_req_i,
    input  logic                    data_we_i,
    input  logic [DATA_WIDTH/8-1:0] data_be_i,
    input  logic [ADDR_WIDTH-1:0]   data_addr_i,
    input  logic [DATA_WIDTH-1:0]   data_wdata_i,
    output logic                    data_gnt_o,
    output logic                    data_rvalid_o,
    output logic [DATA_WIDTH-1:0]   data_rdata_o,
    output logic                    mem_req_o,
    output logic                    mem_we_o,
    output logic [DATA_WIDTH/8-1:0] mem_be_o,
    output logic [ADDR_WIDTH-1:0]   mem_addr_o,
    output logic [DATA_WIDTH-1:0]   mem_wdata_o,
    input  logic                    mem_gnt_i,
    input  logic                    mem_rvalid_i,
    input  logic [DATA_WIDTH-1:0]   mem_rdata_i
);

    localparam int BE_WIDTH     = DATA_WIDTH / 8;
    localparam int STREAK_WIDTH = $clog2(MAX_DATA_STREAK + 1);
    localparam logic [STREAK_WIDTH-1:0] STREAK_MAX = STREAK_WIDTH'(MAX_DATA_STREAK);
    localparam logic [STREAK_WIDTH-1:0] STREAK_ONE = STREAK_WIDTH'(1'b1);
    localparam logic OWNER_INSTR = 1'b0;
    localparam logic OWNER_DATA  = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PENDING = 2'd1,
        ST_RESP    = 2'd2
    } state_t;

    state_t                  state_r;
    logic                    owner_r;
    logic [STREAK_WIDTH-1:0] streak_r;

    logic any_req_s;
    logic win_owner_s;
    logic cur_owner_s;
    logic issue_raw_s;
    logic issue_s;
    logic gnt_s;
    logic resp_s;

    // Arbitration winner and request/response qualification; reset silences everything
    always_comb begin
        any_req_s   = instr_req_i | data_req_i;
        win_owner_s = OWNER_INSTR;
        issue_raw_s = 1'b0;
        if (instr_req_i && data_req_i) begin
            win_owner_s = (streak_r == STREAK_MAX) ? OWNER_INSTR : OWNER_DATA;
        end else if (data_req_i) begin
            win_owner_s = OWNER_DATA;
        end else begin
            win_owner_s = OWNER_INSTR;
        end
        case (state_r)
            ST_IDLE:    issue_raw_s = any_req_s;
            ST_PENDING: issue_raw_s = 1'b1;
            default:    issue_raw_s = 1'b0;
        endcase
        cur_owner_s = (state_r == ST_IDLE) ? win_owner_s : owner_r;
        issue_s     = issue_raw_s & ~rst_i;
        gnt_s       = issue_s & mem_gnt_i;
        resp_s      = ~rst_i & (state_r == ST_RESP) & mem_rvalid_i;
    end

    // Memory request fields muxed from the current owner
    always_comb begin
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_be_o    = {BE_WIDTH{1'b0}};
        mem_addr_o  = {ADDR_WIDTH{1'b0}};
        mem_wdata_o = {DATA_WIDTH{1'b0}};
        if (issue_s) begin
            mem_req_o = 1'b1;
            if (cur_owner_s == OWNER_DATA) begin
                mem_we_o    = data_we_i;
                mem_be_o    = data_be_i;
                mem_addr_o  = data_addr_i;
                mem_wdata_o = data_wdata_i;
            end else begin
                mem_be_o   = {BE_WIDTH{1'b1}};
                mem_addr_o = instr_addr_i;
            end
        end else begin
            mem_req_o = 1'b0;
        end
    end

    // Grant and response steering back to the owning port
    always_comb begin
        instr_gnt_o    = gnt_s & (cur_owner_s == OWNER_INSTR);
        data_gnt_o     = gnt_s & (cur_owner_s == OWNER_DATA);
        instr_rvalid_o = resp_s & (owner_r == OWNER_INSTR);
        data_rvalid_o  = resp_s & (owner_r == OWNER_DATA);
        instr_rdata_o  = instr_rvalid_o ? mem_rdata_i : {DATA_WIDTH{1'b0}};
        data_rdata_o   = data_rvalid_o  ? mem_rdata_i : {DATA_WIDTH{1'b0}};
    end

    // Transaction FSM, owner lock and data-streak counter
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r  <= ST_IDLE;
            owner_r  <= OWNER_INSTR;
            streak_r <= {STREAK_WIDTH{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (any_req_s) begin
                        owner_r <= win_owner_s;
                        state_r <= mem_gnt_i ? ST_RESP : ST_PENDING;
                    end
                end
                ST_PENDING: begin
                    if (mem_gnt_i) begin
                        state_r <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (mem_rvalid_i) begin
                        state_r <= ST_IDLE;
                    end
                end
                default: state_r <= ST_IDLE;
            endcase
            // Only data grants that make a fetch wait count toward starvation
            if (gnt_s) begin
                if (cur_owner_s == OWNER_DATA && instr_req_i) begin
                    if (streak_r != STREAK_MAX) begin
                        streak_r <= streak_r + STREAK_ONE;
                    end
                end else begin
                    streak_r <= {STREAK_WIDTH{1'b0}};
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized scoreboard bench for mem_port_arbiter: a transaction-level model schedules
// each memory access and queues the expected requests, grants and responses.
module tb_mem_port_arbiter;

    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int BW   = DW / 8;
    localparam int MAXS = 4;
    localparam int FW   = 1 + BW + AW + DW;
    localparam int NCYC = 2000;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          instr_req_i;
    logic [AW-1:0] instr_addr_i;
    logic          instr_gnt_o;
    logic          instr_rvalid_o;
    logic [DW-1:0] instr_rdata_o;
    logic          data_req_i;
    logic          data_we_i;
    logic [BW-1:0] data_be_i;
    logic [AW-1:0] data_addr_i;
    logic [DW-1:0] data_wdata_i;
    logic          data_gnt_o;
    logic          data_rvalid_o;
    logic [DW-1:0] data_rdata_o;
    logic          mem_req_o;
    logic          mem_we_o;
    logic [BW-1:0] mem_be_o;
    logic [AW-1:0] mem_addr_o;
    logic [DW-1:0] mem_wdata_o;
    logic          mem_gnt_i;
    logic          mem_rvalid_i;
    logic [DW-1:0] mem_rdata_i;

    always #5 clk_i = ~clk_i;

    mem_port_arbiter #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_DATA_STREAK(MAXS)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .instr_req_i(instr_req_i), .instr_addr_i(instr_addr_i), .instr_gnt_o(instr_gnt_o),
        .instr_rvalid_o(instr_rvalid_o), .instr_rdata_o(instr_rdata_o),
        .data_req_i(data_req_i), .data_we_i(data_we_i), .data_be_i(data_be_i),
        .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i), .data_gnt_o(data_gnt_o),
        .data_rvalid_o(data_rvalid_o), .data_rdata_o(data_rdata_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
    );

    typedef struct { int cyc; logic [FW-1:0] fields; } mem_exp_t;
    typedef struct { int cyc; bit is_data; } gnt_exp_t;
    typedef struct { int cyc; bit is_data; logic [DW-1:0] rdata; } rsp_exp_t;

    mem_exp_t mem_q[$];
    gnt_exp_t gnt_q[$];
    rsp_exp_t rsp_q[$];

    int n_cmp  = 0;
    int n_bad  = 0;
    int cyc    = 0;
    bit mon_on = 1'b1;

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Monitor: pops an expectation whenever the DUT shows an event or one falls due
    mem_exp_t me;
    gnt_exp_t ge;
    rsp_exp_t re;
    always @(negedge clk_i) begin
        if (mon_on) begin
            if (rst_i) begin
                chk("reset_outputs_zero",
                    128'({mem_req_o, mem_we_o, |mem_be_o, |mem_addr_o, |mem_wdata_o,
                          instr_gnt_o, data_gnt_o, instr_rvalid_o, data_rvalid_o,
                          |instr_rdata_o, |data_rdata_o}), 128'(0));
            end else begin
                if (mem_req_o || (mem_q.size() > 0 && mem_q[0].cyc <= cyc)) begin
                    if (mem_q.size() == 0) begin
                        chk("mem_req_unexpected", 128'(mem_req_o), 128'(0));
                    end else begin
                        me = mem_q.pop_front();
                        chk("mem_request",
                            128'({mem_req_o, 32'(cyc), mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o}),
                            128'({1'b1, 32'(me.cyc), me.fields}));
                    end
                end
                if (instr_gnt_o || data_gnt_o || (gnt_q.size() > 0 && gnt_q[0].cyc <= cyc)) begin
                    if (gnt_q.size() == 0) begin
                        chk("grant_unexpected", 128'({instr_gnt_o, data_gnt_o}), 128'(0));
                    end else begin
                        ge = gnt_q.pop_front();
                        chk("grant", 128'({instr_gnt_o, data_gnt_o, 32'(cyc)}),
                            128'({~ge.is_data, ge.is_data, 32'(ge.cyc)}));
                    end
                end
                if (instr_rvalid_o || data_rvalid_o || (rsp_q.size() > 0 && rsp_q[0].cyc <= cyc)) begin
                    if (rsp_q.size() == 0) begin
                        chk("response_unexpected", 128'({instr_rvalid_o, data_rvalid_o}), 128'(0));
                    end else begin
                        re = rsp_q.pop_front();
                        chk("response",
                            128'({instr_rvalid_o, data_rvalid_o, 32'(cyc), instr_rdata_o, data_rdata_o}),
                            128'({~re.is_data, re.is_data, 32'(re.cyc),
                                  re.is_data ? {DW{1'b0}} : re.rdata,
                                  re.is_data ? re.rdata : {DW{1'b0}}}));
                    end
                end else begin
                    chk("rdata_idle_zero", 128'({instr_rdata_o, data_rdata_o}), 128'(0));
                end
            end
        end
    end

    // Requester and memory model state
    bit            ipend, dpend, own_d, reset_done;
    logic [AW-1:0] iaddr, daddr;
    logic          dwe;
    logic [BW-1:0] dbe;
    logic [DW-1:0] dwdata, txn_rdata;
    int            gnt_c, rsp_c, run, rst_until, req_pct, g, r;

    initial begin
        rst_i = 1'b1;
        instr_req_i = 1'b1; instr_addr_i = 32'h0000_0100;
        data_req_i = 1'b1; data_we_i = 1'b1; data_be_i = 4'h3;
        data_addr_i = 32'h0000_2000; data_wdata_i = 32'h0000_1234;
        mem_gnt_i = 1'b1; mem_rvalid_i = 1'b1; mem_rdata_i = 32'hDEAD_BEEF;
        ipend = 1'b0; dpend = 1'b0; own_d = 1'b0; reset_done = 1'b0;
        iaddr = '0; daddr = '0; dwe = 1'b0; dbe = '0; dwdata = '0; txn_rdata = '0;
        gnt_c = -1; rsp_c = -1; run = 0; rst_until = -10; req_pct = 0; g = 0; r = 0;
        repeat (3) @(posedge clk_i);
        #1;
        rst_i = 1'b0; instr_req_i = 1'b0; data_req_i = 1'b0;
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;

        for (int c = 0; c < NCYC + 40; c++) begin
            cyc = c;
            req_pct = (c >= NCYC) ? 0 : ((c >= 100 && c < 300) ? 100 : 60);
            // One reset while a response is outstanding; that response is abandoned
            if (!reset_done && c > 400 && c > gnt_c && c < rsp_c) begin
                reset_done = 1'b1;
                rst_until  = c + 1;
                rsp_q.delete();
                gnt_c = -1; rsp_c = -1; run = 0;
            end
            if (c <= rst_until) begin
                rst_i = 1'b1; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = $urandom;
            end else begin
                rst_i = 1'b0;
                if (!ipend && $urandom_range(99) < req_pct) begin
                    ipend = 1'b1; iaddr = $urandom;
                end
                if (!dpend && $urandom_range(99) < req_pct) begin
                    dpend = 1'b1; dwe = 1'($urandom_range(1)); dbe = BW'($urandom);
                    daddr = $urandom; dwdata = $urandom;
                end
                instr_req_i = ipend; instr_addr_i = iaddr;
                data_req_i = dpend; data_we_i = dwe; data_be_i = dbe;
                data_addr_i = daddr; data_wdata_i = dwdata;
                if (c > rsp_c && (ipend || dpend)) begin
                    own_d = (ipend && dpend) ? (run != MAXS) : dpend;
                    g = int'($urandom_range(3));
                    r = (c > 400 && !reset_done) ? 2 : int'($urandom_range(2));
                    gnt_c = c + g;
                    rsp_c = gnt_c + 1 + r;
                    txn_rdata = (own_d && dwe) ? {DW{1'b0}} : DW'($urandom);
                    for (int k = c; k <= gnt_c; k++) begin
                        mem_q.push_back('{k, own_d ? {dwe, dbe, daddr, dwdata}
                                                   : {1'b0, {BW{1'b1}}, iaddr, {DW{1'b0}}}});
                    end
                    gnt_q.push_back('{gnt_c, own_d});
                    rsp_q.push_back('{rsp_c, own_d, txn_rdata});
                end
                mem_gnt_i    = (c == gnt_c);
                mem_rvalid_i = (c == rsp_c);
                mem_rdata_i  = (c == rsp_c) ? txn_rdata : DW'($urandom);
                if (!(c > gnt_c && c <= rsp_c) && $urandom_range(9) == 0) begin
                    mem_rvalid_i = 1'b1;
                end
                if (c == rst_until + 1) begin
                    mem_rvalid_i = 1'b1; mem_rdata_i = 32'hFFFF_FFFF;
                end
                if (c == gnt_c) begin
                    if (own_d) begin
                        run   = ipend ? ((run < MAXS) ? run + 1 : MAXS) : 0;
                        dpend = 1'b0;
                    end else begin
                        run   = 0;
                        ipend = 1'b0;
                    end
                end
            end
            @(posedge clk_i);
            #1;
        end

        mon_on = 1'b0;
        chk("scoreboard_drained", 128'(mem_q.size() + gnt_q.size() + rsp_q.size()), 128'(0));
        chk("mid_run_reset_exercised", 128'(reset_done), 128'(1));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
